instr_loader: RTL
=================

# instr_loader

Program loader for the instruction memory read by the fetch stage. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into `bus_data`-bit instruction words, and writes them to consecutive instruction-memory addresses from 0 to a programmed last address. While loading, `busy` holds the core so fetch never reads a half-written program.

## Interface
- `bus_address`, 6, instruction-memory address width (2^6 = 64 words)
- `bus_data`, 32, instruction word width; multiple of 8; bytes per word `NB = bus_data/8`

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load; sampled only in IDLE
- `last_addr`  in  bus_address  final word address to write; sampled with `start`
- `abort`  in  1  cancel the load in progress
- `byte_in`  in  8  stream data byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  instruction-memory write strobe
- `wr_addr`  out  bus_address  write address
- `wr_data`  out  bus_data  write data
- `busy`  out  1  load in progress; holds the core and fetch
- `done`  out  1  one-cycle pulse when the final word has been written

## Operation
- Byte transfer happens on a rising edge where `byte_valid && byte_ready`.
- **States:** IDLE, COLLECT, WRITE, DONE.
- **IDLE:**
  - `busy=0`, `byte_ready=0`.
  - `start=1` latches `last_addr`, clears the word address to 0 and the lane counter to 0, then goes to COLLECT.
- **COLLECT:**
  - `byte_ready=1`.
  - Each accepted byte goes into lane `lane` of the assembly register, at bits `[8*lane+7 : 8*lane]`. The first byte is the LSB. `lane` then increments.
  - When lane `NB-1` is accepted, go to WRITE and reset `lane` to 0.
- **WRITE:**
  - `byte_ready=0`, `wr_en=1` for exactly this one cycle.
  - `wr_addr` is the current word address; `wr_data` is the assembled word.
  - If word address == latched last address, go to DONE. Otherwise increment the word address and go to COLLECT.
- **DONE:** `done=1` for one cycle, then IDLE.
- `busy=1` in COLLECT, WRITE and DONE.
- **abort:**
  - In COLLECT or WRITE, `abort=1` sends the FSM to IDLE next cycle.
  - The partial word is discarded and `done` is not pulsed.
  - `abort` in WRITE still completes that cycle's write, since `wr_en` is already asserted.
  - A byte presented with `abort` in COLLECT is not counted. `byte_ready` stays 1 in COLLECT, so the source sees a transfer, but it is dropped.
  - `abort` in IDLE or DONE is ignored.
- `start` while not in IDLE is ignored. `last_addr` changes after the `start` cycle have no effect.
- The word address never wraps. `last_addr = 2^bus_address-1` writes every location exactly once and stops.
- `wr_addr` and `wr_data` hold their last values outside WRITE. Consumers qualify them with `wr_en` only.

## Timing
- **Reset:**
  - `rst=1` at any time forces IDLE on the next edge.
  - Clears: `byte_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`, `lane=0`, word address 0.
  - Reset mid-load discards the partial word and performs no write.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- `start` at edge N: `busy=1` and `byte_ready=1` from cycle N+1.
- 4th byte (`NB`th) accepted at edge M: `wr_en=1` during cycle M+1, with data stable for the whole cycle. The instruction memory may capture on either clock edge.
- Minimum `NB+1` cycles per word with back-to-back bytes.
- Full load of `L+1` words: `(L+1)*(NB+1)` cycles from the first COLLECT cycle to the DONE cycle, with no bubbles.
- `byte_valid` gaps stall COLLECT indefinitely without changing state.
- `done` is asserted in the cycle after the last WRITE. `busy` drops one cycle after `done`.

## Test plan
- **Single word:** reset, then `start` with `last_addr=0`, bytes 0x78,0x56,0x34,0x12 back-to-back → one `wr_en` pulse with `wr_addr=0`, `wr_data=0x12345678`; `done` 1 cycle later; `busy` high for exactly 6 cycles.
- **Three words with gaps:** `last_addr=2`, random `byte_valid` gaps → writes at addresses 0,1,2 with correct little-endian words, in order; exactly 3 `wr_en` pulses; no write during gaps.
- **Full memory:** `last_addr=63`, word k = k*0x01010101 → 64 writes at addresses 0..63, no wrap to 0; `done` once; a second `start` afterwards reloads from address 0.
- **Abort:** `abort` after 2 bytes of word 1 (with `last_addr=3`) → word 0 written, no further `wr_en`, no `done`, `busy=0` the next cycle. Then `start` on a fresh load works normally.
- **Reset mid-load:** `rst` in WRITE of word 2, and separately after 3 bytes in COLLECT → all outputs at reset values the next cycle; in the COLLECT case no write occurs.
- **Ignored start:** `start` pulsed mid-load with a different `last_addr` → load continues to the original `last_addr`, the word address is not reset, and `done` pulses once.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader -- program loader for the fetch-stage instruction memory.
//
// Accepts a byte stream over a valid/ready handshake, packs bytes
// little-endian into bus_data-bit words and writes them to consecutive
// instruction-memory addresses 0 .. last_addr.  busy holds the core while
// a load is in progress.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, last_addr  begin a load (IDLE only); last_addr latched with start
//   abort             cancel the load in progress (COLLECT / WRITE)
//   byte_in           stream byte
//   byte_valid        byte_in is valid
//   byte_ready        loader accepts a byte this cycle (COLLECT)
//   wr_en             instruction-memory write strobe (one cycle per word)
//   wr_addr, wr_data  write address / data, held between writes
//   busy              load in progress
//   done              one-cycle pulse after the final word is written
module instr_loader #(
  parameter int bus_address = 6,
  parameter int bus_data    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [bus_address-1:0] last_addr,
  input  logic                   abort,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [bus_address-1:0] wr_addr,
  output logic [bus_data-1:0]    wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam int NB     = bus_data / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  logic [bus_address-1:0] word_addr;
  logic [bus_address-1:0] last_q;
  logic [LANE_W-1:0]      lane;
  logic [bus_data-1:0]    word_p0;
  logic [bus_data-1:0]    word_next;

  // Assembly word with the incoming byte merged into the current lane.
  always_comb begin
    word_next = word_p0;
    for (int i = 0; i < NB; i++) begin
      if (lane == LANE_W'(i)) begin
        word_next[8*i +: 8] = byte_in;
      end
    end
  end

  // Assembly register: only the lanes written before a WRITE are ever used,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == COLLECT && byte_valid && !abort) begin
      word_p0 <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_addr <= '0;
      last_q    <= '0;
      lane      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q    <= last_addr;
            word_addr <= '0;
            lane      <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          // abort wins over a byte presented in the same cycle; the byte is dropped
          if (abort) begin
            lane  <= '0;
            state <= IDLE;
          end else if (byte_valid) begin
            if (lane == LAST_LANE) begin
              // Write port is loaded here so address/data are stable for the
              // whole WRITE cycle and hold afterwards.
              lane    <= '0;
              wr_addr <= word_addr;
              wr_data <= word_next;
              state   <= WRITE;
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        WRITE: begin
          // The write itself happens this cycle regardless of abort.
          if (abort) begin
            state <= IDLE;
          end else if (word_addr == last_q) begin
            state <= DONE;
          end else begin
            word_addr <= word_addr + 1'b1;
            state     <= COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state only.
  assign byte_ready = (state == COLLECT);
  assign wr_en      = (state == WRITE);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

endmodule
